// File: rtl/rsa_decrypt_reader_pkg.sv
// rsa_decrypt_reader_pkg: shared widths, FSM encoding and modular multiplier timing
package rsa_decrypt_reader_pkg;
  localparam int WIDTH = 32;
  localparam int DEPTH_LOG2 = 5;
  localparam int MODMUL_CYCLES = WIDTH + 1;
  localparam int BIT_W = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, CHECK, SQUARE, MULT, EMIT, FINISH} state_t;
endpackage

// File: rtl/rsa_decrypt_reader_if.sv
// rsa_decrypt_reader_if: batch control, operand store read port and plaintext output bundle
interface rsa_decrypt_reader_if;
  import rsa_decrypt_reader_pkg::*;
  logic start;
  logic [DEPTH_LOG2:0] num_entries;
  logic rd_en;
  logic [WIDTH-1:0] n_in, d_in, c_in, m_out;
  logic [DEPTH_LOG2-1:0] m_idx;
  logic m_valid, err, busy, done;
  modport master (output start, num_entries, n_in, d_in, c_in,
                  input rd_en, m_out, m_idx, m_valid, err, busy, done);
  modport slave (input start, num_entries, n_in, d_in, c_in,
                 output rd_en, m_out, m_idx, m_valid, err, busy, done);
endinterface

// File: rtl/rsa_decrypt_reader_modmul.sv
// rsa_modmul: sequential MSB-first shift-add computing a*b mod n (1 load + WIDTH step cycles)
module rsa_modmul
  import rsa_decrypt_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic mm_done
);
  logic [WIDTH-1:0] r_q, b_q;
  logic [BIT_W-1:0] cnt_q;
  logic run_q;
  logic [WIDTH:0] t0, t1, t2, t3;
  // one step: double, reduce, conditionally add a, reduce; WIDTH+1 bits hold 2n-1
  always_comb begin
    t0 = {r_q, 1'b0};
    t1 = t0 >= {1'b0, n} ? t0 - {1'b0, n} : t0;
    t2 = b_q[WIDTH-1] ? t1 + {1'b0, a} : t1;
    t3 = t2 >= {1'b0, n} ? t2 - {1'b0, n} : t2;
  end
  assign r = t3[WIDTH-1:0];
  assign mm_done = run_q && cnt_q == '0;
  // load on go, then walk b from MSB; the final step result is presented alongside mm_done
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      r_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
    end else if (go) begin
      run_q <= 1'b1;
      r_q <= '0;
      b_q <= b;
      cnt_q <= BIT_W'(WIDTH - 1);
    end else if (run_q) begin
      r_q <= t3[WIDTH-1:0];
      b_q <= b_q << 1;
      cnt_q <= cnt_q - 1'b1;
      run_q <= cnt_q != '0;
    end
  end
endmodule

// File: rtl/rsa_decrypt_reader.sv
// rsa_decrypt_reader: drains (n,d,c) entries and emits m = c^d mod n per entry
module rsa_decrypt_reader
  import rsa_decrypt_reader_pkg::*;
(
  input logic clk,
  input logic rst,
  rsa_decrypt_reader_if.slave bus
);
  state_t state_q;
  logic [WIDTH-1:0] n_q, d_q, c_q, acc_q, m_out_q, mm_b, mm_r;
  logic [BIT_W-1:0] bit_q;
  logic [DEPTH_LOG2-1:0] idx_q, m_idx_q;
  logic [DEPTH_LOG2:0] num_q;
  logic bad, bad_q, go_q, rd_en_q, m_valid_q, err_q, busy_q, done_q, mm_done;
  assign bad = n_q < WIDTH'(2) || c_q >= n_q;
  assign mm_b = state_q == MULT ? c_q : acc_q;
  rsa_modmul u_mm (.clk, .rst, .go(go_q), .a(acc_q), .b(mm_b), .n(n_q), .r(mm_r), .mm_done);
  assign bus.rd_en = rd_en_q;
  assign bus.m_out = m_out_q;
  assign bus.m_idx = m_idx_q;
  assign bus.m_valid = m_valid_q;
  assign bus.err = err_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // batch sequencer: fetch, validate, square-and-multiply over all exponent bits, emit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      d_q <= '0;
      c_q <= '0;
      acc_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      num_q <= '0;
      bad_q <= 1'b0;
      go_q <= 1'b0;
      rd_en_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_out_q <= '0;
      m_idx_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      go_q <= 1'b0;
      rd_en_q <= 1'b0;
      m_valid_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          busy_q <= 1'b1;
          idx_q <= '0;
          num_q <= bus.num_entries;
          rd_en_q <= bus.num_entries != '0;
          state_q <= bus.num_entries == '0 ? FINISH : FETCH;
        end
        FETCH: state_q <= CAPTURE;
        CAPTURE: begin
          n_q <= bus.n_in;
          d_q <= bus.d_in;
          c_q <= bus.c_in;
          acc_q <= WIDTH'(1);
          bit_q <= BIT_W'(WIDTH - 1);
          state_q <= CHECK;
        end
        CHECK: begin
          bad_q <= bad;
          acc_q <= bad ? '0 : acc_q;
          go_q <= !bad;
          state_q <= bad ? EMIT : SQUARE;
        end
        SQUARE: if (mm_done) begin
          acc_q <= mm_r;
          if (d_q[bit_q]) begin
            go_q <= 1'b1;
            state_q <= MULT;
          end else if (bit_q == '0) begin
            state_q <= EMIT;
          end else begin
            bit_q <= bit_q - 1'b1;
            go_q <= 1'b1;
          end
        end
        MULT: if (mm_done) begin
          acc_q <= mm_r;
          if (bit_q == '0) begin
            state_q <= EMIT;
          end else begin
            bit_q <= bit_q - 1'b1;
            go_q <= 1'b1;
            state_q <= SQUARE;
          end
        end
        EMIT: begin
          m_valid_q <= 1'b1;
          m_out_q <= acc_q;
          m_idx_q <= idx_q;
          err_q <= bad_q;
          idx_q <= idx_q + 1'b1;
          if ({1'b0, idx_q} + 1'b1 == num_q) begin
            state_q <= FINISH;
          end else begin
            rd_en_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_decrypt_reader.sv
// tb_rsa_decrypt_reader: directed batches against a store model and a native-arithmetic reference
module tb_rsa_decrypt_reader;
  import rsa_decrypt_reader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr = 0;
  int mv_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [WIDTH-1:0] mem_n [32];
  logic [WIDTH-1:0] mem_d [32];
  logic [WIDTH-1:0] mem_c [32];
  logic [WIDTH-1:0] exp_m [32];
  logic [WIDTH-1:0] mv_m [64];
  logic [DEPTH_LOG2-1:0] mv_idx [64];
  logic mv_err [64];
  int mv_cyc [64];
  int rd_cyc [64];
  rsa_decrypt_reader_if bus();
  rsa_decrypt_reader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // operand store model: one-cycle read latency, pointer cleared by the bench between batches
  always @(posedge clk) begin
    if (clr) ptr <= 0;
    else if (bus.rd_en) begin
      bus.n_in <= mem_n[ptr % 32];
      bus.d_in <= mem_d[ptr % 32];
      bus.c_in <= mem_c[ptr % 32];
      ptr <= ptr + 1;
    end
  end
  // output monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      mv_cnt <= 0;
      rd_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (bus.rd_en && rd_cnt < 64) begin
        rd_cyc[rd_cnt] <= cyc;
        rd_cnt <= rd_cnt + 1;
      end
      if (bus.m_valid && mv_cnt < 64) begin
        mv_m[mv_cnt] <= bus.m_out;
        mv_idx[mv_cnt] <= bus.m_idx;
        mv_err[mv_cnt] <= bus.err;
        mv_cyc[mv_cnt] <= cyc;
        mv_cnt <= mv_cnt + 1;
      end
      if (bus.done) begin
        done_cyc <= cyc;
        done_cnt <= done_cnt + 1;
      end
    end
  end
  function automatic logic [WIDTH-1:0] ref_m(input logic [WIDTH-1:0] n, d, c);
    logic [63:0] r;
    r = 64'd1;
    if (n < 2 || c >= n) return '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = (r * r) % {32'd0, n};
      if (d[i]) r = (r * {32'd0, c}) % {32'd0, n};
    end
    return r[WIDTH-1:0];
  endfunction
  function automatic int lat(input logic [WIDTH-1:0] d);
    return 3 + MODMUL_CYCLES * (WIDTH + $countones(d)) + 1;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic load(input int i, input logic [WIDTH-1:0] n, d, c);
    mem_n[i] = n;
    mem_d[i] = d;
    mem_c[i] = c;
  endtask
  task automatic clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic pulse_start(input int n);
    bus.num_entries = (DEPTH_LOG2 + 1)'(n);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int bound, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      step();
      k++;
    end
    chk(tag, done_cnt != 0, 1);
  endtask
  task automatic run(input int n, input string tag);
    clear();
    pulse_start(n);
    wait_done(70000, tag);
    step();
  endtask
  initial begin
    logic [WIDTH-1:0] rn, rd, rc;
    bus.start = 1'b0;
    bus.num_entries = '0;
    repeat (3) step();
    chk("reset_ctl", {bus.rd_en, bus.m_valid, bus.err, bus.busy, bus.done}, 0);
    chk("reset_m_out", bus.m_out, 0);
    chk("reset_m_idx", bus.m_idx, 0);
    rst = 1'b0;
    step();
    load(0, 33, 7, 8);
    run(1, "t1_done");
    chk("t1_rd_cnt", rd_cnt, 1);
    chk("t1_mv_cnt", mv_cnt, 1);
    chk("t1_m", mv_m[0], 2);
    chk("t1_idx", mv_idx[0], 0);
    chk("t1_err", mv_err[0], 0);
    chk("t1_lat", mv_cyc[0] - rd_cyc[0], lat(7));
    chk("t1_done_gap", done_cyc - mv_cyc[0], 1);
    chk("t1_busy", bus.busy, 0);
    load(0, 3233, 2753, 2790);
    run(1, "t2_done");
    chk("t2_m", mv_m[0], 65);
    chk("t2_lat", mv_cyc[0] - rd_cyc[0], lat(2753));
    chk("t2_hold_m", bus.m_out, 65);
    load(0, 32'hFFFF_FFFB, 32, 2);
    run(1, "t3_done");
    chk("t3_m", mv_m[0], 5);
    chk("t3_err", mv_err[0], 0);
    load(0, 33, 0, 5);
    load(1, 1, 3, 0);
    load(2, 33, 3, 40);
    run(3, "t4_done");
    chk("t4_rd_cnt", rd_cnt, 3);
    chk("t4_mv_cnt", mv_cnt, 3);
    chk("t4_m0", mv_m[0], 1);
    chk("t4_e0", mv_err[0], 0);
    chk("t4_m1", mv_m[1], 0);
    chk("t4_e1", mv_err[1], 1);
    chk("t4_m2", mv_m[2], 0);
    chk("t4_e2", mv_err[2], 1);
    chk("t4_idx", {mv_idx[0], mv_idx[1], mv_idx[2]}, {5'd0, 5'd1, 5'd2});
    chk("t4_err_lat", mv_cyc[1] - rd_cyc[1], 4);
    chk("t4_hold_err", bus.err, 1);
    run(0, "t5_done");
    chk("t5_mv_cnt", mv_cnt, 0);
    chk("t5_rd_cnt", rd_cnt, 0);
    for (int i = 0; i < 32; i++) begin
      rn = $urandom;
      if (rn < 2) rn = 2;
      rc = $urandom % rn;
      rd = $urandom;
      load(i, rn, rd, rc);
      exp_m[i] = ref_m(rn, rd, rc);
    end
    clear();
    pulse_start(32);
    repeat (200) step();
    pulse_start(3);
    repeat (500) step();
    pulse_start(1);
    wait_done(70000, "b32_done");
    repeat (50) step();
    chk("b32_mv_cnt", mv_cnt, 32);
    chk("b32_rd_cnt", rd_cnt, 32);
    chk("b32_done_cnt", done_cnt, 1);
    chk("b32_busy", bus.busy, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("b32_m%0d", i), mv_m[i], exp_m[i]);
      chk($sformatf("b32_idx%0d", i), mv_idx[i], i);
    end
    load(0, 3233, 2753, 2790);
    clear();
    pulse_start(1);
    repeat (40) step();
    rst = 1'b1;
    step();
    chk("rst_ctl", {bus.rd_en, bus.m_valid, bus.err, bus.busy, bus.done}, 0);
    chk("rst_m_out", bus.m_out, 0);
    chk("rst_m_idx", bus.m_idx, 0);
    rst = 1'b0;
    repeat (1300) step();
    chk("rst_no_valid", mv_cnt, 0);
    chk("rst_no_done", done_cnt, 0);
    run(1, "rst_rerun_done");
    chk("rst_rerun_m", mv_m[0], 65);
    chk("rst_rerun_idx", mv_idx[0], 0);
    chk("rst_rerun_rd", rd_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
